// File: rtl/div_pkg.sv
// Shared types and constants for the iterative integer divider.
package div_pkg;

  localparam int unsigned W_WORD = 32;

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    PREP = 5'b00010,
    ITER = 5'b00100,
    FIX  = 5'b01000,
    DONE = 5'b10000
  } div_state_e;

  typedef struct packed {
    logic is_signed;
    logic is_word;
    logic want_rem;
  } div_req_t;

endpackage

// File: rtl/div_lzc.sv
// Leading-zero counter used to skip leading dividend zeros.
// Compiled only when DIVIDER_EARLY_TERM_EN is defined.
`ifdef DIVIDER_EARLY_TERM_EN
module div_lzc #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = $clog2(XLEN + 1)
) (
  input  logic [XLEN-1:0]  value,
  output logic [CNT_W-1:0] count_c
);

  logic found;

  // Scan from the MSB; an all-zero value reports XLEN.
  always_comb begin
    count_c = CNT_W'(XLEN);
    found   = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (!found && value[i]) begin
        count_c = CNT_W'(XLEN - 1 - i);
        found   = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/rv_iter_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// Define DIVIDER_EARLY_TERM_EN to skip leading dividend zeros.
module rv_iter_divider
  import div_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  input  logic            is_word,
  input  logic            want_rem,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            busy
);

  div_state_e state_q, state_d;
  div_req_t   req_q;

  logic [XLEN-1:0]  a_q, b_q, quo_q, rem_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q, r_neg_q;

  logic             accept_c;
  logic [XLEN-1:0]  a_ext_c, b_ext_c, a_mag_c, b_mag_c, a_align_c, min_c;
  logic             a_neg_c, b_neg_c, div_zero_c, ovf_c;
  logic [CNT_W-1:0] w_c, cnt_init_c;
  logic [XLEN-1:0]  quo_init_c;
  logic [XLEN:0]    rem_sh_c, sub_c;
  logic [XLEN-1:0]  q_fix_c, r_fix_c, sel_c, res_c;

  assign accept_c = in_valid && in_ready && !flush;

  // Operand preparation: extension, magnitudes and special-case detection.
  always_comb begin
    if (req_q.is_word) begin
      a_ext_c = req_q.is_signed ? XLEN'($signed(a_q[W_WORD-1:0])) : XLEN'(a_q[W_WORD-1:0]);
      b_ext_c = req_q.is_signed ? XLEN'($signed(b_q[W_WORD-1:0])) : XLEN'(b_q[W_WORD-1:0]);
      min_c   = XLEN'($signed(32'h8000_0000));
      w_c     = CNT_W'(W_WORD);
    end else begin
      a_ext_c = a_q;
      b_ext_c = b_q;
      min_c   = {1'b1, {(XLEN-1){1'b0}}};
      w_c     = CNT_W'(XLEN);
    end
    a_neg_c    = req_q.is_signed && a_ext_c[XLEN-1];
    b_neg_c    = req_q.is_signed && b_ext_c[XLEN-1];
    a_mag_c    = a_neg_c ? -a_ext_c : a_ext_c;
    b_mag_c    = b_neg_c ? -b_ext_c : b_ext_c;
    div_zero_c = (b_ext_c == '0);
    ovf_c      = req_q.is_signed && (a_ext_c == min_c) && (b_ext_c == '1);
    // Left-justify the W-bit dividend so iteration consumes its MSB first.
    a_align_c  = req_q.is_word ? (a_mag_c << (XLEN - W_WORD)) : a_mag_c;
  end

`ifdef DIVIDER_EARLY_TERM_EN
  logic [CNT_W-1:0] lzc_c, lz_c;

  div_lzc #(.XLEN(XLEN), .CNT_W(CNT_W)) u_lzc (
    .value   (a_align_c),
    .count_c (lzc_c)
  );

  always_comb begin
    lz_c       = (lzc_c > w_c) ? w_c : lzc_c;
    quo_init_c = a_align_c << lz_c;
    cnt_init_c = (lz_c == w_c) ? CNT_W'(1) : (w_c - lz_c);
  end
`else
  always_comb begin
    quo_init_c = a_align_c;
    cnt_init_c = w_c;
  end
`endif

  // One restoring step; the borrow bit of the trial subtraction is the compare.
  always_comb begin
    rem_sh_c = {rem_q, quo_q[XLEN-1]};
    sub_c    = rem_sh_c - {1'b0, dvs_q};
  end

  // Sign fix-up and result selection.
  always_comb begin
    q_fix_c = q_neg_q ? -quo_q : quo_q;
    r_fix_c = r_neg_q ? -rem_q : rem_q;
    sel_c   = req_q.want_rem ? r_fix_c : q_fix_c;
    res_c   = req_q.is_word ? XLEN'($signed(sel_c[W_WORD-1:0])) : sel_c;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = PREP;
      PREP:    state_d = (div_zero_c || ovf_c) ? FIX : ITER;
      ITER:    if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  // Datapath registers; nothing changes in a flush cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      req_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      out_data <= '0;
    end else if (!flush) begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            a_q             <= dividend;
            b_q             <= divisor;
            req_q.is_signed <= is_signed;
            req_q.is_word   <= is_word;
            req_q.want_rem  <= want_rem;
          end
        end
        PREP: begin
          q_neg_q <= 1'b0;
          r_neg_q <= 1'b0;
          if (div_zero_c) begin
            quo_q <= '1;
            rem_q <= a_ext_c;
          end else if (ovf_c) begin
            quo_q <= a_ext_c;
            rem_q <= '0;
          end else begin
            quo_q   <= quo_init_c;
            rem_q   <= '0;
            dvs_q   <= b_mag_c;
            cnt_q   <= cnt_init_c;
            q_neg_q <= a_neg_c ^ b_neg_c;
            r_neg_q <= a_neg_c;
          end
        end
        ITER: begin
          quo_q <= {quo_q[XLEN-2:0], ~sub_c[XLEN]};
          rem_q <= sub_c[XLEN] ? rem_sh_c[XLEN-1:0] : sub_c[XLEN-1:0];
          cnt_q <= cnt_q - CNT_W'(1);
        end
        FIX:     out_data <= res_c;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_iter_divider.sv
// Directed self-checking bench for rv_iter_divider (XLEN=64, default build).
module tb_rv_iter_divider;

  localparam int unsigned XLEN = 64;

  logic            clk, rst, flush, in_valid, in_ready;
  logic [XLEN-1:0] dividend, divisor, out_data;
  logic            is_signed, is_word, want_rem, out_valid, out_ready, busy;

  int errors = 0;
  int checks = 0;

  rv_iter_divider #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .is_signed(is_signed), .is_word(is_word), .want_rem(want_rem),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request on the falling edge and let the next rising edge take it.
  task automatic accept_op(input logic [63:0] a, input logic [63:0] b,
                           input logic s, input logic w, input logic r);
    @(negedge clk);
    dividend = a; divisor = b; is_signed = s; is_word = w; want_rem = r;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = '1; divisor = 64'h0000_0000_0000_0003;
    is_signed = ~s; is_word = ~w; want_rem = ~r;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 200);
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL timeout: out_valid never rose within %0d cycles", lat);
    end
  endtask

  task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic w, input logic r,
                       output logic [63:0] res, output int lat);
    accept_op(a, b, s, w, r);
    wait_valid(lat);
    res = out_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0; is_signed = 1'b0; is_word = 1'b0; want_rem = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_unsigned;
    logic [63:0] res; int lat;
    do_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, res, lat);
    checks++; if (res !== 64'd14) begin errors++; $display("FAIL divu_100_7 got=%h exp=%h", res, 64'd14); end
    checks++; if (lat !== 66) begin errors++; $display("FAIL divu_latency got=%0d exp=66", lat); end
    do_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b1, res, lat);
    checks++; if (res !== 64'd2) begin errors++; $display("FAIL remu_100_7 got=%h exp=%h", res, 64'd2); end
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0, 1'b0, res, lat);
    checks++; if (res !== 64'h5555_5555_5555_5555) begin errors++; $display("FAIL divu_max_3 got=%h exp=5555555555555555", res); end
  endtask

  task automatic test_signed;
    logic [63:0] res; int lat;
    do_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0, res, lat);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_m7_2 got=%h exp=fffffffffffffffd", res); end
    do_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b1, res, lat);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rem_m7_2 got=%h exp=ffffffffffffffff", res); end
    do_op(64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, res, lat);
    checks++; if (res !== 64'd3) begin errors++; $display("FAIL div_m7_m2 got=%h exp=3", res); end
    do_op(64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1, res, lat);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rem_m7_m2 got=%h exp=ffffffffffffffff", res); end
  endtask

  task automatic test_special;
    logic [63:0] res; int lat;
    do_op(64'd5, 64'd0, 1'b1, 1'b0, 1'b0, res, lat);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL div_by_zero got=%h exp=ffffffffffffffff", res); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL div_by_zero_latency got=%0d exp=2", lat); end
    do_op(64'd5, 64'd0, 1'b1, 1'b0, 1'b1, res, lat);
    checks++; if (res !== 64'd5) begin errors++; $display("FAIL rem_by_zero got=%h exp=5", res); end
    do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, res, lat);
    checks++; if (res !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL div_overflow got=%h exp=8000000000000000", res); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL overflow_latency got=%0d exp=2", lat); end
    do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, res, lat);
    checks++; if (res !== 64'h0) begin errors++; $display("FAIL rem_overflow got=%h exp=0", res); end
  endtask

  task automatic test_word;
    logic [63:0] res; int lat;
    do_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0, res, lat);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL divuw_sext got=%h exp=ffffffffffffffff", res); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL word_latency got=%0d exp=34", lat); end
    do_op(64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, res, lat);
    checks++; if (res !== 64'h0) begin errors++; $display("FAIL remw_overflow got=%h exp=0", res); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL remw_overflow_latency got=%0d exp=2", lat); end
    do_op(64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 1'b1, 1'b1, 1'b0, res, lat);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL divw_upper_ignored got=%h exp=fffffffffffffffd", res); end
    do_op(64'h0000_0001_0000_0011, 64'h0000_0000_0000_0010, 1'b0, 1'b1, 1'b1, res, lat);
    checks++; if (res !== 64'd1) begin errors++; $display("FAIL remuw_17_16 got=%h exp=1", res); end
  endtask

  task automatic test_flush;
    logic [63:0] res; int lat;
    accept_op(64'd1000, 64'd7, 1'b0, 1'b0, 1'b0);
    repeat (11) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL flush_iter busy=%b in_ready=%b out_valid=%b exp=0/1/0", busy, in_ready, out_valid); end
    // Flush outranks a simultaneous request.
    @(negedge clk);
    dividend = 64'd50; divisor = 64'd5; is_signed = 1'b0; is_word = 1'b0; want_rem = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_vs_accept busy=%b exp=0", busy); end
    do_op(64'd9, 64'd3, 1'b0, 1'b0, 1'b0, res, lat);
    checks++; if (res !== 64'd3) begin errors++; $display("FAIL after_flush got=%h exp=3", res); end
    checks++; if (lat !== 66) begin errors++; $display("FAIL after_flush_latency got=%0d exp=66", lat); end
  endtask

  task automatic test_hold;
    int lat;
    out_ready = 1'b0;
    accept_op(64'd9, 64'd3, 1'b0, 1'b0, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 64'd3)
        begin errors++; $display("FAIL hold_%0d out_valid=%b out_data=%h exp=1/3", i, out_valid, out_data); end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL hold_release out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back;
    int lat;
    accept_op(64'd20, 64'd4, 1'b0, 1'b0, 1'b0);
    wait_valid(lat);
    checks++; if (out_data !== 64'd5) begin errors++; $display("FAIL b2b_first got=%h exp=5", out_data); end
    dividend = 64'd30; divisor = 64'd5; is_signed = 1'b0; is_word = 1'b0; want_rem = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL b2b_retire_no_accept busy=%b out_valid=%b exp=0/0", busy, out_valid); end
    @(posedge clk); #1; in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b exp=1", busy); end
    wait_valid(lat);
    checks++; if (out_data !== 64'd6) begin errors++; $display("FAIL b2b_second got=%h exp=6", out_data); end
    checks++; if (lat !== 66) begin errors++; $display("FAIL b2b_latency got=%0d exp=66", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [63:0] res; int lat;
    accept_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'h0)
      begin errors++; $display("FAIL reset_mid busy=%b in_ready=%b out_data=%h exp=0/1/0", busy, in_ready, out_data); end
    @(negedge clk); rst = 1'b0;
    do_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, res, lat);
    checks++; if (res !== 64'd14) begin errors++; $display("FAIL after_reset got=%h exp=e", res); end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_special;
    test_word;
    test_flush;
    test_hold;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
